// File: rtl/interrupt_unit.sv
// interrupt_unit
//   Memory-mapped interrupt controller in front of the multicycle RV32 core.
//   Device lines are latched into pending bits, filtered by per-source enables
//   and the global enable, and the lowest-numbered requesting source is
//   presented on irq/icause. The request is held until the core returns iack,
//   after which irq is forced low for HOLDOFF_CYC cycles before re-arbitration.
//
// Parameters
//   NSRC        number of interrupt sources (1..16)
//   HOLDOFF_CYC irq forced-low cycles after each iack (1..15)
//
// Ports
//   clk, rst     system clock, synchronous active-high reset
//   irq_src      raw device interrupt lines, active-high
//   irq, icause  request and source index to the core; icause stable while irq=1
//   iack         one-cycle acknowledge from the core
//   cs, a, d     chip select, address (a[3:2] decoded), write data
//   we, rd       write / read strobes (both together count as a write)
//   spo, ready   read data and one-cycle completion strobe
//
// Register map (word offset a[3:2])
//   0 PENDING  read; write-1-to-clear on edge-type bits
//   1 ENABLE   RW
//   2 EDGE     RW, 1 = rising-edge source, 0 = level source
//   3 CTRL     bit0 GIE (RW), bits[11:8] icause (RO), bit16 irq (RO)
//
// Build option
//   INTC_SYNC_EN  when defined, irq_src passes through a 2-flop synchronizer
//                 before sampling (needed for asynchronous sources); this adds
//                 two cycles to every source latency.
//
// FSM states
//   state  | meaning
//   IDLE   | no request outstanding; arbitrate when GIE and any req
//   REQ    | irq=1, icause frozen, waiting for iack or withdrawal
//   HOLD   | irq=0 while the holdoff counter runs down after an iack

module interrupt_unit #(
  parameter int NSRC        = 16,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  output logic            irq,
  output logic [3:0]      icause,
  input  logic            iack,
  input  logic            cs,
  input  logic [31:0]     a,
  input  logic [31:0]     d,
  input  logic            we,
  input  logic            rd,
  output logic [31:0]     spo,
  output logic            ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_CYC);

  state_t          state_q, state_d;
  logic [3:0]      icause_q, icause_d;
  logic [3:0]      hold_cnt_q, hold_cnt_d;
  logic [NSRC-1:0] src_in;
  logic [NSRC-1:0] src_q, src_prev_q;
  logic [NSRC-1:0] pend_edge_q, pend_edge_d;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic            gie_q, gie_d;
  logic            ready_q;
  logic [31:0]     spo_q, spo_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_view;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] ack_clr;
  logic [3:0]      winner;
  logic            ack_take;
  logic            acc;
  logic            wr_en;
  logic            rd_only;
  logic [1:0]      reg_off;
  logic [31:0]     rd_data;

  logic            unused_bus;
  assign unused_bus = ^{a[31:4], a[1:0], d};

  // ---------------------------------------------------------------------------
  // Source sampling
  // ---------------------------------------------------------------------------
`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = irq_src;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q      <= '0;
      src_prev_q <= '0;
    end else begin
      src_q      <= src_in;
      src_prev_q <= src_q;
    end
  end

  assign rise = src_q & ~src_prev_q;

  // Level sources are transparent onto PENDING; edge sources use the stored bit.
  assign pend_view = (edge_q & pend_edge_q) | (~edge_q & src_q);
  assign req       = pend_view & enable_q;

  always_comb begin
    winner = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) winner = 4'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode and register updates
  // ---------------------------------------------------------------------------
  assign acc     = cs & (rd | we);
  assign wr_en   = cs & we;
  assign rd_only = cs & rd & ~we;
  assign reg_off = a[3:2];

  assign ack_clr = ack_take ? (NSRC'(1) << icause_q) : '0;

  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    gie_d    = gie_q;
    clr_mask = '0;
    if (wr_en) begin
      case (reg_off)
        2'd0:    clr_mask = d[NSRC-1:0];
        2'd1:    enable_d = d[NSRC-1:0];
        2'd2:    edge_d   = d[NSRC-1:0];
        default: gie_d    = d[0];
      endcase
    end
    // A rise beats a same-cycle clear; masking with the next EDGE value drops
    // any stored bit when a source is switched back to level mode.
    pend_edge_d = ((pend_edge_q & ~(clr_mask | ack_clr)) | rise) & edge_d;
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      2'd0: rd_data[NSRC-1:0] = pend_view;
      2'd1: rd_data[NSRC-1:0] = enable_q;
      2'd2: rd_data[NSRC-1:0] = edge_q;
      default: begin
        rd_data[0]    = gie_q;
        rd_data[11:8] = icause_q;
        rd_data[16]   = irq;
      end
    endcase
  end

  assign spo_d = rd_only ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_edge_q <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      gie_q       <= 1'b0;
      ready_q     <= 1'b0;
      spo_q       <= '0;
    end else begin
      pend_edge_q <= pend_edge_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      gie_q       <= gie_d;
      ready_q     <= acc;
      spo_q       <= spo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    icause_d   = icause_q;
    hold_cnt_d = hold_cnt_q;
    ack_take   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gie_q && (|req)) begin
          icause_d = winner;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // iack takes precedence over a simultaneous withdraw condition.
        if (iack) begin
          ack_take   = 1'b1;
          hold_cnt_d = HOLD_INIT;
          state_d    = S_HOLD;
        end else if (!req[icause_q] || !gie_q) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q - 4'd1;
        if (hold_cnt_d == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      icause_q   <= 4'd0;
      hold_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      icause_q   <= icause_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign irq    = (state_q == S_REQ);
  assign icause = icause_q;
  assign spo    = spo_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Testbench for interrupt_unit: directed scenarios followed by a random phase,
// all checked every cycle against a behavioural model of the controller.
module tb_interrupt_unit;

  localparam int NSRC = 16;
  localparam int HOLD = 2;
`ifdef INTC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_src;
  logic        irq;
  logic [3:0]  icause;
  logic        iack;
  logic        cs;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  always #5 clk = ~clk;

  interrupt_unit #(.NSRC(NSRC), .HOLDOFF_CYC(HOLD)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .irq(irq), .icause(icause),
    .iack(iack), .cs(cs), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending-edge bits, configuration, the outstanding
  // request (if any) and the number of forced-low cycles still to run.
  logic [15:0] m_pend, m_en, m_edge;
  logic [15:0] m_pipe [0:3];
  logic        m_gie, m_irq, m_ready;
  logic [3:0]  m_cause;
  logic [31:0] m_spo;
  int          m_hold;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_edge = '0; m_gie = 1'b0;
    m_irq = 1'b0; m_cause = '0; m_hold = 0; m_ready = 1'b0; m_spo = '0;
    for (int i = 0; i < 4; i++) m_pipe[i] = '0;
  endtask

  task automatic model_step();
    logic [15:0] sq, sqd, pv, req, clr, rise, edge_n;
    logic [31:0] rdata;
    logic        wr, rdo, ack_hit;
    int          off;
    if (rst) begin
      model_reset();
      return;
    end
    sq  = m_pipe[SYNC];
    sqd = m_pipe[SYNC+1];
    pv  = (m_edge & m_pend) | (~m_edge & sq);
    req = pv & m_en;
    wr  = cs & we;
    rdo = cs & rd & ~we;
    off = int'(a[3:2]);
    case (off)
      0:       rdata = {16'h0, pv};
      1:       rdata = {16'h0, m_en};
      2:       rdata = {16'h0, m_edge};
      default: rdata = 32'(m_gie) | (32'(m_cause) << 8) | (32'(m_irq) << 16);
    endcase
    m_ready = cs & (rd | we);
    m_spo   = rdo ? rdata : 32'h0;
    ack_hit = 1'b0;
    if (m_irq) begin
      if (iack) begin
        ack_hit = 1'b1;
        m_irq   = 1'b0;
        m_hold  = HOLD;
      end else if (!req[m_cause] || !m_gie) begin
        m_irq = 1'b0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_gie && req != 0) begin
      for (int i = 15; i >= 0; i--) if (req[i]) m_cause = 4'(i);
      m_irq = 1'b1;
    end
    clr = (wr && off == 0) ? d[15:0] : 16'h0;
    if (ack_hit) clr = clr | (16'(1) << m_cause);
    rise   = sq & ~sqd;
    edge_n = (wr && off == 2) ? d[15:0] : m_edge;
    m_pend = ((m_pend & ~clr) | rise) & edge_n;
    m_edge = edge_n;
    if (wr && off == 1) m_en = d[15:0];
    if (wr && off == 3) m_gie = d[0];
    for (int i = 3; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = irq_src;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("irq", 32'(irq), 32'(m_irq));
    chk("icause", 32'(icause), 32'(m_cause));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("spo", spo, m_spo);
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [31:0] data);
    cs = 1'b1; we = 1'b1; rd = 1'b0; a = {28'h0, off, 2'b00}; d = data;
    tick();
    cs = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic bus_rd(input logic [1:0] off, output logic [31:0] data);
    cs = 1'b1; rd = 1'b1; we = 1'b0; a = {28'h0, off, 2'b00};
    tick();
    data = spo;
    chk("rd_ready", 32'(ready), 32'd1);
    cs = 1'b0; rd = 1'b0;
    tick();
    chk("rd_ready_drop", 32'(ready), 32'd0);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    chk("irq_wait", 32'(irq), 32'd1);
  endtask

  task automatic pulse(input logic [15:0] mask);
    irq_src = irq_src | mask;
    tick();
    irq_src = irq_src & ~mask;
  endtask

  initial begin
    logic [31:0] v;
    int n;
    rst = 1'b1; irq_src = '0; iack = 1'b0; cs = 1'b0; a = '0; d = '0; we = 1'b0; rd = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick();

    bus_rd(2'd3, v);
    chk("ctrl_after_reset", v, 32'h0);

    // Edge source 3: latency, iack clears pending, holdoff, stays low.
    bus_wr(2'd2, 32'h8);
    bus_wr(2'd1, 32'h8);
    bus_wr(2'd3, 32'h1);
    pulse(16'h0008);
    n = 1;
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    chk("edge_latency", n, 3 + SYNC);
    chk("edge_cause", 32'(icause), 32'd3);
    iack = 1'b1; tick(); iack = 1'b0;
    chk("edge_ack_low", 32'(irq), 32'd0);
    repeat (5) tick();
    chk("edge_stays_low", 32'(irq), 32'd0);
    bus_rd(2'd0, v);
    chk("edge_pend_cleared", v & 32'h8, 32'h0);

    // Level source 5: re-request after holdoff, then drop the line.
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd1, 32'h20);
    irq_src[5] = 1'b1;
    wait_irq(n);
    chk("level_cause", 32'(icause), 32'd5);
    iack = 1'b1; tick(); iack = 1'b0;
    n = 1;
    chk("level_ack_low", 32'(irq), 32'd0);
    while (!irq && n < 40) begin
      tick();
      n++;
    end
    chk("level_rearm_gap", n, HOLD + 2);
    chk("level_cause_again", 32'(icause), 32'd5);
    irq_src[5] = 1'b0;
    repeat (2 + SYNC) tick();
    bus_rd(2'd0, v);
    chk("level_pend_drop", v & 32'h20, 32'h0);

    // Sources 2 and 7 together: lowest index first.
    bus_wr(2'd2, 32'h84);
    bus_wr(2'd1, 32'h84);
    pulse(16'h0084);
    wait_irq(n);
    chk("prio_first", 32'(icause), 32'd2);
    iack = 1'b1; tick(); iack = 1'b0;
    wait_irq(n);
    chk("prio_second", 32'(icause), 32'd7);
    iack = 1'b1; tick(); iack = 1'b0;
    repeat (4) tick();

    // Source 4: withdraw on disable, then disable together with iack.
    bus_wr(2'd2, 32'h10);
    bus_wr(2'd1, 32'h10);
    pulse(16'h0010);
    wait_irq(n);
    chk("wd_cause", 32'(icause), 32'd4);
    bus_wr(2'd1, 32'h0);
    chk("wd_irq_low", 32'(irq), 32'd0);
    bus_rd(2'd0, v);
    chk("wd_pend_kept", v & 32'h10, 32'h10);
    bus_wr(2'd1, 32'h10);
    wait_irq(n);
    cs = 1'b1; we = 1'b1; a = 32'h4; d = 32'h0; iack = 1'b1;
    tick();
    cs = 1'b0; we = 1'b0; iack = 1'b0;
    chk("ack_wins_irq", 32'(irq), 32'd0);
    tick();
    bus_rd(2'd0, v);
    chk("ack_wins_pend", v & 32'h10, 32'h0);

    // Reset while a request is outstanding.
    bus_wr(2'd1, 32'h10);
    pulse(16'h0010);
    wait_irq(n);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_irq", 32'(irq), 32'd0);
    chk("rst_mid_cause", 32'(icause), 32'd0);
    tick();
    bus_rd(2'd1, v);
    chk("rst_mid_enable", v, 32'h0);
    bus_rd(2'd3, v);
    chk("rst_mid_ctrl", v, 32'h0);

    // W1C colliding with a rise on source 0: set wins; plain W1C clears.
    bus_wr(2'd2, 32'h1);
    irq_src[0] = 1'b1;
    repeat (1 + SYNC) tick();
    bus_wr(2'd0, 32'h1);
    bus_rd(2'd0, v);
    chk("w1c_vs_rise", v & 32'h1, 32'h1);
    irq_src[0] = 1'b0;
    bus_wr(2'd0, 32'h1);
    bus_rd(2'd0, v);
    chk("w1c_clear", v & 32'h1, 32'h0);

    // Random phase.
    bus_wr(2'd3, 32'h1);
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 16; b++) if ($urandom_range(0, 15) == 0) irq_src[b] = ~irq_src[b];
      cs   = ($urandom_range(0, 3) == 0);
      rd   = 1'(($urandom_range(0, 1)));
      we   = 1'(($urandom_range(0, 2) == 0));
      a    = $urandom;
      d    = $urandom;
      if (a[3:2] == 2'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      iack = m_irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      rst  = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; cs = 1'b0; rd = 1'b0; we = 1'b0; iack = 1'b0; irq_src = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
